// File: rtl/seg_bin2bcd.sv
// seg_bin2bcd: 32-bit unsigned binary to 8-digit display word using iterative double dabble.
// Latency: start accepted at edge k, 32 shift edges follow, and the result plus o_done are registered at edge k+33.
// Backpressure: none; i_start is only sampled in IDLE and is otherwise dropped (no queueing).
// Build option: SEG_BIN2BCD_LZB_EN selects an active-low segment output with leading-zero blanking.
module seg_bin2bcd (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_start,
    input  logic [31:0] i_bin,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ovf,
    output logic [63:0] o_data,
    output logic        o_mode
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

`ifdef SEG_BIN2BCD_LZB_EN
    localparam logic        MODE     = 1'b1;
    localparam logic [63:0] RST_WORD = 64'hFFFF_FFFF_FFFF_FFC0;

    // Active-low segment pattern for one decimal digit.
    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 8'hC0;
            4'd1:    seg_enc = 8'hF9;
            4'd2:    seg_enc = 8'hA4;
            4'd3:    seg_enc = 8'hB0;
            4'd4:    seg_enc = 8'h99;
            4'd5:    seg_enc = 8'h92;
            4'd6:    seg_enc = 8'h82;
            4'd7:    seg_enc = 8'hF8;
            4'd8:    seg_enc = 8'h80;
            4'd9:    seg_enc = 8'h90;
            default: seg_enc = 8'hFF;
        endcase
    endfunction
`else
    localparam logic        MODE     = 1'b0;
    localparam logic [63:0] RST_WORD = 64'h0;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] bin_sr;
    logic [39:0] bcd;
    logic [4:0]  cnt;
    logic [35:0] bcd_adj;
    logic [39:0] bcd_shift;
    logic [63:0] result;

    assign o_mode = MODE;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: 32 shift edges, then a single result cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = SHIFT;
            SHIFT:   if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on digits 0..8, then the 1-bit left shift of {bcd, bin}.
    // Digit 9 never exceeds 4 for a 32-bit input, so it needs no correction.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 9; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else                       bcd_adj[4*i +: 4] = bcd[4*i +: 4];
        end
        bcd_shift = {bcd[38:36], bcd_adj, bin_sr[31]};
    end

    // Conversion datapath: load on accepted start, iterate while in SHIFT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_sr <= '0;
            bcd    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        bin_sr <= i_bin;
                        bcd    <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    bcd    <= bcd_shift;
                    bin_sr <= {bin_sr[30:0], 1'b0};
                    cnt    <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SEG_BIN2BCD_LZB_EN
    // Segment encoding of the low eight digits, blanking zeros above the top nonzero digit.
    always_comb begin
        logic seen;
        seen   = 1'b0;
        result = '1;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0) seen = 1'b1;
            if (seen || i == 0) result[8*i +: 8] = seg_enc(bcd[4*i +: 4]);
        end
    end
`else
    // Plain BCD: digit 0 in the low nibble, upper word unused.
    always_comb begin
        result = {32'h0, bcd[31:0]};
    end
`endif

    // Registered handshake and result outputs; o_data/o_ovf hold until the next result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_ovf  <= 1'b0;
            o_data <= RST_WORD;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE:  if (i_start) o_busy <= 1'b1;
                DONE: begin
                    o_data <= result;
                    o_ovf  <= (bcd[39:32] != 8'h0);
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_bin2bcd.sv
// Testbench for seg_bin2bcd: directed vector table plus hand-written handshake sequences.
// Latency: expects o_done/o_busy fall 33 edges after the accepting edge.
// Backpressure: checks that a start issued mid-conversion is dropped.
module tb_seg_bin2bcd;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_bin = '0;
    logic        o_busy;
    logic        o_done;
    logic        o_ovf;
    logic [63:0] o_data;
    logic        o_mode;

    int total = 0;
    int bad   = 0;

`ifdef SEG_BIN2BCD_LZB_EN
    localparam logic        EXP_MODE = 1'b1;
    localparam logic [63:0] EXP_RST  = 64'hFFFF_FFFF_FFFF_FFC0;
`else
    localparam logic        EXP_MODE = 1'b0;
    localparam logic [63:0] EXP_RST  = 64'h0;
`endif

    seg_bin2bcd dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_start (i_start),
        .i_bin   (i_bin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_ovf   (o_ovf),
        .o_data  (o_data),
        .o_mode  (o_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bin;
        logic [31:0] bcd;   // hand-computed low eight decimal digits
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected display word built from hand-written BCD digits.
    function automatic logic [63:0] exp_word(input logic [31:0] bcd);
        logic [63:0] w;
`ifdef SEG_BIN2BCD_LZB_EN
        logic seen;
        logic [7:0] s;
        seen = 1'b0;
        w = '1;
        for (int i = 7; i >= 0; i--) begin
            case (bcd[4*i +: 4])
                4'd0: s = 8'hC0;  4'd1: s = 8'hF9;  4'd2: s = 8'hA4;  4'd3: s = 8'hB0;
                4'd4: s = 8'h99;  4'd5: s = 8'h92;  4'd6: s = 8'h82;  4'd7: s = 8'hF8;
                4'd8: s = 8'h80;  4'd9: s = 8'h90;  default: s = 8'hFF;
            endcase
            if (bcd[4*i +: 4] != 4'd0) seen = 1'b1;
            if (seen || i == 0) w[8*i +: 8] = s;
        end
`else
        w = {32'h0, bcd};
`endif
        return w;
    endfunction

    // Called #1 after a posedge. Issues a start, optionally pulses a second start
    // after edge k+pulse_at, and reports the edge offset of o_done and busy cycles.
    task automatic run_conv(input logic [31:0] bin, input int pulse_at, input logic [31:0] pulse_bin,
                            output int done_at, output int busy_cnt);
        int n;
        i_start = 1'b1;
        i_bin   = bin;
        @(posedge clk); #1;
        i_start  = 1'b0;
        n        = 0;
        busy_cnt = 0;
        done_at  = -1;
        while (n < 45 && done_at < 0) begin
            if (o_busy) busy_cnt++;
            if (o_done) done_at = n;
            else begin
                if (n == pulse_at) begin i_start = 1'b1; i_bin = pulse_bin; end
                else begin i_start = 1'b0; end
                @(posedge clk); #1;
                n++;
            end
        end
        i_start = 1'b0;
        if (done_at < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: no o_done within 45 cycles for input %0d", bin);
        end
    endtask

    initial begin
        int d_at, b_cnt;

        vecs[0]  = '{32'd0,          32'h00000000, 1'b0};
        vecs[1]  = '{32'd12345678,   32'h12345678, 1'b0};
        vecs[2]  = '{32'd4294967295, 32'h94967295, 1'b1};
        vecs[3]  = '{32'd99999999,   32'h99999999, 1'b0};
        vecs[4]  = '{32'd100000000,  32'h00000000, 1'b1};
        vecs[5]  = '{32'd305,        32'h00000305, 1'b0};
        vecs[6]  = '{32'd9,          32'h00000009, 1'b0};
        vecs[7]  = '{32'd10,         32'h00000010, 1'b0};
        vecs[8]  = '{32'd1000000,    32'h01000000, 1'b0};
        vecs[9]  = '{32'd4000000000, 32'h00000000, 1'b1};
        vecs[10] = '{32'd87654321,   32'h87654321, 1'b0};

        // Reset state
        #12;
        chk("rst_busy", {63'h0, o_busy}, 64'h0);
        chk("rst_done", {63'h0, o_done}, 64'h0);
        chk("rst_ovf",  {63'h0, o_ovf},  64'h0);
        chk("rst_data", o_data, EXP_RST);
        chk("mode",     {63'h0, o_mode}, {63'h0, EXP_MODE});
        rstn = 1'b1;
        @(posedge clk); #1;

        // Vector table
        foreach (vecs[i]) begin
            run_conv(vecs[i].bin, -1, 32'h0, d_at, b_cnt);
            chk($sformatf("v%0d_latency", i), 64'(d_at), 64'd33);
            chk($sformatf("v%0d_busy_cycles", i), 64'(b_cnt), 64'd33);
            chk($sformatf("v%0d_data", i), o_data, exp_word(vecs[i].bcd));
            chk($sformatf("v%0d_ovf", i), {63'h0, o_ovf}, {63'h0, vecs[i].ovf});
            chk($sformatf("v%0d_busy_at_done", i), {63'h0, o_busy}, 64'h0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {63'h0, o_done}, 64'h0);
            chk($sformatf("v%0d_hold", i), o_data, exp_word(vecs[i].bcd));
        end

        // Start during conversion is dropped
        run_conv(32'd305, 10, 32'd999, d_at, b_cnt);
        chk("ignore_latency", 64'(d_at), 64'd33);
        chk("ignore_data", o_data, exp_word(32'h00000305));
`ifdef SEG_BIN2BCD_LZB_EN
        chk("ignore_seg_word", o_data, 64'hFFFF_FFFF_FFB0_C092);
`endif
        @(posedge clk); #1;
        chk("ignore_no_second_busy", {63'h0, o_busy}, 64'h0);

        // Back-to-back: start in the o_done cycle
        run_conv(32'd777, -1, 32'h0, d_at, b_cnt);
        chk("b2b_first_data", o_data, exp_word(32'h00000777));
        run_conv(32'd42, -1, 32'h0, d_at, b_cnt);
        chk("b2b_latency", 64'(d_at), 64'd33);
        chk("b2b_data", o_data, exp_word(32'h00000042));
        @(posedge clk); #1;

        // Reset mid-conversion
        i_start = 1'b1;
        i_bin   = 32'd12345678;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("mid_busy_before_rst", {63'h0, o_busy}, 64'h1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", {63'h0, o_busy}, 64'h0);
        chk("mid_rst_data", o_data, EXP_RST);
        chk("mid_rst_ovf",  {63'h0, o_ovf},  64'h0);
        begin
            int dones = 0;
            for (int c = 0; c < 40; c++) begin
                if (c == 2) rstn = 1'b1;
                @(posedge clk); #1;
                if (o_done) dones++;
            end
            chk("mid_rst_no_done", 64'(dones), 64'd0);
        end
        run_conv(32'd2024, -1, 32'h0, d_at, b_cnt);
        chk("post_rst_latency", 64'(d_at), 64'd33);
        chk("post_rst_data", o_data, exp_word(32'h00002024));
        chk("post_rst_ovf", {63'h0, o_ovf}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
